// File: rtl/digital_lock_pio_in_irq_pkg.sv
// Shared constants for the lock's interrupt-capable input PIO:
// Avalon register addresses and edge-detection modes.
package digital_lock_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/digital_lock_pio_in_irq_if.sv
// Avalon-MM slave bus of the input PIO, including its level interrupt line.
interface digital_lock_pio_in_irq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/digital_lock_pio_in_irq_debounce.sv
// Single-bit debouncer: output follows the input only once it has held a new
// value for DEBOUNCE_CYCLES consecutive clocks.
module digital_lock_pio_debounce #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] count_reg;
    logic          stable_reg;

    // Any cycle where the input agrees with the stable value restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg  <= '0;
            stable_reg <= RESET_BIT;
        end else if (din != stable_reg) begin
            if (count_reg == LAST) begin
                stable_reg <= din;
                count_reg  <= '0;
            end else begin
                count_reg  <= count_reg + 1'b1;
            end
        end else begin
            count_reg <= '0;
        end
    end

    assign dout = stable_reg;

endmodule

// File: rtl/digital_lock_pio_in_irq.sv
// Avalon-MM input PIO with synchroniser, sticky edge capture, IRQ mask and level IRQ.
// Optional per-bit debounce is enabled by defining DIGITAL_LOCK_PIO_DEBOUNCE_EN.
module digital_lock_pio_in_irq
    import digital_lock_pio_pkg::*;
#(
    parameter int          WIDTH           = 10,
    parameter int          EDGE_MODE       = EDGE_RISE,
    parameter logic [31:0] RESET_VALUE     = 32'h0,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_port,
    digital_lock_pio_in_irq_if.slave bus
);

    localparam logic [WIDTH-1:0] RST_BITS = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] edge_bits;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] edge_capture_reg;
    logic [31:0]      readdata_reg;
    logic [31:0]      readdata_next;
    logic             irq_reg;
    logic             wr_en;
    logic             unused_writedata;

    // Synchroniser flops start at RESET_VALUE so keys idling high do not fake an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= RST_BITS;
            sync2_reg <= RST_BITS;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef DIGITAL_LOCK_PIO_DEBOUNCE_EN
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        digital_lock_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RST_BITS[gi])
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .din   (sync2_reg[gi]),
            .dout  (data_in[gi])
        );
    end
`else
    assign data_in = sync2_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg <= RST_BITS;
        end else begin
            prev_reg <= data_in;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
        logic rise_bit;
        logic fall_bit;
        assign rise_bit      = data_in[gi] & ~prev_reg[gi];
        assign fall_bit      = ~data_in[gi] & prev_reg[gi];
        assign edge_bits[gi] = (EDGE_MODE == EDGE_FALL) ? fall_bit :
                               (EDGE_MODE == EDGE_ANY)  ? (rise_bit | fall_bit) :
                                                          rise_bit;
    end

    assign wr_en            = bus.chipselect & ~bus.write_n;
    assign clr_bits         = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
    assign unused_writedata = ^bus.writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_reg <= '0;
        end else if (wr_en && bus.address == ADDR_MASK) begin
            irq_mask_reg <= bus.writedata[WIDTH-1:0];
        end
    end

    // A fresh edge overrides a simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture_reg <= '0;
        end else begin
            edge_capture_reg <= (edge_capture_reg & ~clr_bits) | edge_bits;
        end
    end

    always_comb begin
        readdata_next = '0;
        case (bus.address)
            ADDR_DATA: readdata_next[WIDTH-1:0] = data_in;
            ADDR_MASK: readdata_next[WIDTH-1:0] = irq_mask_reg;
            ADDR_EDGE: readdata_next[WIDTH-1:0] = edge_capture_reg;
            default:   readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            readdata_reg <= readdata_next;
            irq_reg      <= |(edge_capture_reg & irq_mask_reg);
        end
    end

    assign bus.readdata = readdata_reg;
    assign bus.irq      = irq_reg;

endmodule

// File: tb/tb_digital_lock_pio_in_irq.sv
// Scoreboard bench for the input PIO: stimulus queues expected read/irq values,
// a monitor compares them one cycle later against the bus outputs.
module tb_digital_lock_pio_in_irq;
    import digital_lock_pio_pkg::*;

    localparam int WIDTH = 10;

    typedef struct {
        bit          is_irq;
        logic [31:0] value;
        string       name;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_port;
    logic             issue = 1'b0;
    logic             pend  = 1'b0;
    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;

    digital_lock_pio_in_irq_if bus ();

    digital_lock_pio_in_irq #(
        .WIDTH           (WIDTH),
        .EDGE_MODE       (EDGE_RISE),
        .RESET_VALUE     (32'h0),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end else begin
            $display("ok   %s value=%08h", name, act);
        end
    endtask

    // The read/irq issued in a cycle is visible on the bus after the next edge.
    always @(posedge clk) pend <= issue;

    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                compare(e.name, e.is_irq ? {31'b0, bus.irq} : bus.readdata, e.value);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            issue = 1'b0;
        end
    endtask

    task automatic expect_read(input logic [1:0] addr, input logic [31:0] val, input string name);
        exp_t e;
        bus.address = addr;
        e.is_irq = 1'b0;
        e.value  = val;
        e.name   = name;
        exp_q.push_back(e);
        issue = 1'b1;
    endtask

    task automatic expect_irq(input logic val, input string name);
        exp_t e;
        e.is_irq = 1'b1;
        e.value  = {31'b0, val};
        e.name   = name;
        exp_q.push_back(e);
        issue = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = data;
        tick(1);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        in_port        = '0;
        bus.address    = ADDR_DATA;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        tick(2);
        reset = 1'b0;
        tick(1);

        expect_read(ADDR_DATA, 32'h0, "rst_data");  tick(1);
        expect_read(ADDR_EDGE, 32'h0, "rst_edge");  tick(1);
        expect_read(ADDR_MASK, 32'h0, "rst_mask");  tick(1);
        expect_irq(1'b0, "rst_irq");                tick(1);

`ifdef DIGITAL_LOCK_PIO_DEBOUNCE_EN
        in_port = 10'h001;
        tick(3);
        in_port = 10'h000;
        tick(8);
        expect_read(ADDR_DATA, 32'h0, "db_glitch_data"); tick(1);
        expect_read(ADDR_EDGE, 32'h0, "db_glitch_edge"); tick(1);
        in_port = 10'h001;
        tick(10);
        expect_read(ADDR_DATA, 32'h1, "db_stable_data"); tick(1);
        expect_read(ADDR_EDGE, 32'h1, "db_stable_edge"); tick(1);
`else
        // Data path and reserved word
        in_port = 10'h2A5;
        tick(3);
        expect_read(ADDR_DATA, 32'h0000_02A5, "data_2a5");  tick(1);
        expect_read(ADDR_RSVD, 32'h0, "rsvd_read");         tick(1);
        expect_read(ADDR_EDGE, 32'h0000_02A5, "edge_2a5");  tick(1);
        bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
        expect_read(ADDR_RSVD, 32'h0, "rsvd_write");        tick(1);

        // Falling edges are ignored in rising mode; clear everything
        in_port = 10'h000;
        bus_write(ADDR_EDGE, 32'hFFFF_FFFF);
        tick(3);
        expect_read(ADDR_EDGE, 32'h0, "w1c_all");           tick(1);

        // Upper writedata bits are dropped
        bus_write(ADDR_MASK, 32'hFFFF_F004);
        expect_read(ADDR_MASK, 32'h0000_0004, "mask_004");  tick(1);

        // Rising edge on bit 2: irq appears 4 cycles after the pin change
        in_port = 10'h004;
        tick(2);
        expect_irq(1'b0, "irq_pre");                        tick(1);
        expect_irq(1'b1, "irq_rise");                       tick(1);
        expect_read(ADDR_EDGE, 32'h0000_0004, "edge_b2");   tick(1);

        in_port = 10'h00C;
        tick(4);
        expect_read(ADDR_EDGE, 32'h0000_000C, "edge_b3");   tick(1);

        // Clear bit 2: irq still high after the write edge, low one cycle later
        expect_irq(1'b1, "irq_hold");
        bus_write(ADDR_EDGE, 32'h0000_0004);
        expect_irq(1'b0, "irq_clr_masked_b3");              tick(1);
        expect_read(ADDR_EDGE, 32'h0000_0008, "w1c_b2");    tick(1);
        bus_write(ADDR_EDGE, 32'h0000_0000);
        expect_read(ADDR_EDGE, 32'h0000_0008, "w1c_zero");  tick(1);

        // Clear of bit 0 lands on the same edge as its synchronised rise
        in_port = 10'h00D;
        tick(2);
        bus_write(ADDR_EDGE, 32'h0000_0001);
        expect_read(ADDR_EDGE, 32'h0000_0009, "collide");   tick(1);

        // Read in the capture cycle sees the old value
        in_port = 10'h01D;
        tick(2);
        expect_read(ADDR_EDGE, 32'h0000_0009, "pre_update");  tick(1);
        expect_read(ADDR_EDGE, 32'h0000_0019, "post_update"); tick(1);

        // Asynchronous reset in the middle of operation
        bus_write(ADDR_MASK, 32'h0000_03FF);
        tick(1);
        expect_irq(1'b1, "irq_all");                        tick(1);
        in_port = 10'h000;
        tick(4);
        expect_read(ADDR_EDGE, 32'h0000_0019, "pre_reset"); tick(1);
        tick(1);
        reset = 1'b1;
        #2;
        compare("async_rst_readdata", bus.readdata, 32'h0);
        compare("async_rst_irq", {31'b0, bus.irq}, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(1);
        expect_read(ADDR_MASK, 32'h0, "post_rst_mask");     tick(1);
        expect_read(ADDR_EDGE, 32'h0, "post_rst_edge");     tick(1);
        expect_irq(1'b0, "post_rst_irq");                   tick(1);
`endif

        tick(2);
        compare("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
